ram_arbiter: RTL
================

# ram_arbiter

Two-port round-robin arbiter that shares the single-port data RAM between the CPU data path and the debug/loader port. Each cycle it grants at most one requester, drives the RAM's address, write-data, memread and memwrite inputs, and steers the RAM's one-cycle-late registered read data back to the requester that issued the read. It also rejects out-of-range addresses with an error response and keeps saturating per-port grant counters for bring-up.

## Interface
- DEPTH, 256: number of RAM words; valid addresses are 0..DEPTH-1.
- CNT_W, 16: width of the grant counters.

- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- cpu_req / dbg_req  in  1  request valid; held until ready.
- cpu_we / dbg_we  in  1  1 = write, 0 = read.
- cpu_addr / dbg_addr  in  32  word address.
- cpu_wdata / dbg_wdata  in  32  write data.
- cpu_ready / dbg_ready  out  1  request accepted this cycle (combinational).
- cpu_rvalid / dbg_rvalid  out  1  read response valid.
- cpu_rdata / dbg_rdata  out  32  read data, 0 when rvalid=0.
- cpu_err / dbg_err  out  1  accepted request was out of range; pulses with the response slot.
- ram_addr  out  32  to RAM addr.
- ram_write_data  out  32  to RAM write_data.
- ram_memread / ram_memwrite  out  1  to RAM memread/memwrite.
- ram_read_data  in  32  from RAM read_data.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_cpu / cnt_dbg  out  CNT_W  grants issued per port.

## Operation
- Grant, combinational each cycle:
  - Only one port requesting: that port wins.
  - Both requesting: the port selected by `prio` wins.
  - Neither requesting: no grant, memread=memwrite=0.
- `prio` register: after any grant to port X, `prio` <= the other port. Reset value: CPU.
- Granted request with addr < DEPTH:
  - ram_addr and ram_write_data are driven from the winner.
  - ram_memwrite = we; ram_memread = ~we.
- Granted request with addr >= DEPTH:
  - The request is accepted (ready=1) but not forwarded; memread=memwrite=0.
  - Counts as a grant for `prio` and for the counters.
- Idle RAM-side values: ram_addr=0, ram_write_data=0, memread=memwrite=0.
- Response tag register {valid, port, is_err} is loaded on every granted read or errored request. Writes without error produce no response.
- Response cycle: rvalid=1 for the tagged port.
  - rdata = ram_read_data, or 0 if is_err.
  - err = is_err.
  - An errored write gives rvalid=0, err=1.
- Counters:
  - cnt_x increments on each grant to x and saturates at all-ones.
  - cnt_clr zeroes both counters and takes priority over an increment in the same cycle.
- While reset is high: all outputs 0, tag invalid, counters 0, `prio`=CPU.

## Timing
- Accept latency: ready is asserted in the same cycle as req when granted. There is no bubble between back-to-back grants.
- Read latency: 1 cycle. Grant in cycle N, so the RAM samples at the end of N, and rvalid/rdata are valid in cycle N+1.
- Pipelined reads: a new grant in cycle N+1 overlaps with the response to cycle N; throughput is 1 access per cycle.
- Write followed by read of the same address on the next cycle returns the new data, because the RAM write commits at the edge ending the write cycle.
- Requester rules:
  - Must keep req/we/addr/wdata stable until ready.
  - May deassert req only after ready.
  - Has no backpressure on responses.
- Reset mid-operation: reset asserted during the response cycle or earlier clears rvalid immediately (asynchronous). A read granted before reset never produces a response after reset release.
- Starvation bound: with both ports continuously requesting, each port waits at most 1 cycle.

## Test plan
- Reset, then cpu write addr 5 = 0xDEADBEEF, then cpu read addr 5 -> cpu_ready=1 on both cycles; cpu_rvalid=1, cpu_rdata=0xDEADBEEF one cycle after the read grant; dbg_rvalid stays 0.
- cpu_req and dbg_req both held for 6 reads of distinct addresses after reset -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG. Each rvalid returns on the matching port one cycle later; cnt_cpu=3, cnt_dbg=3.
- dbg read addr 256 with DEPTH=256 -> dbg_ready=1; ram_memread=0; next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0. cpu write addr 300 -> cpu_err pulse with cpu_rvalid=0, RAM contents unchanged.
- cpu read granted in cycle N, reset asserted in cycle N+1 before the edge -> cpu_rvalid=0 throughout reset and afterwards; `prio`=CPU after release, so a simultaneous request is granted to CPU first.
- Force cnt_cpu to 0xFFFE, then issue 3 cpu grants -> 0xFFFF with no wrap. cnt_clr asserted together with a grant -> counter reads 0 next cycle.
- Single dbg requester streaming 4 writes while cpu_req=0 -> dbg_ready=1 on 4 consecutive cycles, with no forced alternation.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for one port of the data RAM arbiter.
// The master is the requester and the slave is the arbiter.
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares the data RAM between the CPU and debug ports.
// It also flags out-of-range accesses and keeps saturating grant counters.
module ram_arbiter #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  ram_arbiter_if.slave     cpu,
  ram_arbiter_if.slave     dbg,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_write_data,
  output logic             ram_memread,
  output logic             ram_memwrite,
  input  logic [31:0]      ram_read_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_cpu,
  output logic [CNT_W-1:0] cnt_dbg
);
  typedef enum logic {
    P_CPU = 1'b0,
    P_DBG = 1'b1
  } port_e;

  localparam logic [31:0] LIMIT = 32'(DEPTH);

  port_e            prio_q, prio_d;
  logic             gnt_cpu, gnt_dbg, gnt;
  logic             sel_we;
  logic [31:0]      sel_addr, sel_wdata;
  logic             in_rng, fwd;

  logic             tag_v_q, tag_v_d;
  port_e            tag_p_q, tag_p_d;
  logic             tag_e_q, tag_e_d;
  logic             tag_w_q, tag_w_d;
  logic             rsp_rd;

  logic [CNT_W-1:0] cnt_cpu_q, cnt_cpu_d;
  logic [CNT_W-1:0] cnt_dbg_q, cnt_dbg_d;

  always_comb begin
    gnt_cpu = ~reset & cpu.req & (~dbg.req | (prio_q == P_CPU));
    gnt_dbg = ~reset & dbg.req & ~gnt_cpu;
    gnt     = gnt_cpu | gnt_dbg;

    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      gnt_cpu: begin
        sel_we    = cpu.we;
        sel_addr  = cpu.addr;
        sel_wdata = cpu.wdata;
      end
      gnt_dbg: begin
        sel_we    = dbg.we;
        sel_addr  = dbg.addr;
        sel_wdata = dbg.wdata;
      end
      default: ;
    endcase

    in_rng = sel_addr < LIMIT;
    fwd    = gnt & in_rng;
  end

  assign cpu.ready = gnt_cpu;
  assign dbg.ready = gnt_dbg;

  assign ram_addr       = fwd ? sel_addr : '0;
  assign ram_write_data = fwd ? sel_wdata : '0;
  assign ram_memwrite   = fwd & sel_we;
  assign ram_memread    = fwd & ~sel_we;

  always_comb begin
    prio_d = prio_q;
    if (gnt) prio_d = gnt_cpu ? P_DBG : P_CPU;

    // Errored writes take a slot too, so their err pulse lines up.
    tag_v_d = gnt & (~sel_we | ~in_rng);
    tag_p_d = gnt_dbg ? P_DBG : P_CPU;
    tag_e_d = ~in_rng;
    tag_w_d = sel_we;

    cnt_cpu_d = cnt_cpu_q;
    cnt_dbg_d = cnt_dbg_q;
    if (cnt_clr) begin
      cnt_cpu_d = '0;
      cnt_dbg_d = '0;
    end else begin
      if (gnt_cpu && !(&cnt_cpu_q))
        cnt_cpu_d = cnt_cpu_q + CNT_W'(1);
      if (gnt_dbg && !(&cnt_dbg_q))
        cnt_dbg_d = cnt_dbg_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prio_q    <= P_CPU;
      tag_v_q   <= 1'b0;
      tag_p_q   <= P_CPU;
      tag_e_q   <= 1'b0;
      tag_w_q   <= 1'b0;
      cnt_cpu_q <= '0;
      cnt_dbg_q <= '0;
    end else begin
      prio_q    <= prio_d;
      tag_v_q   <= tag_v_d;
      tag_p_q   <= tag_p_d;
      tag_e_q   <= tag_e_d;
      tag_w_q   <= tag_w_d;
      cnt_cpu_q <= cnt_cpu_d;
      cnt_dbg_q <= cnt_dbg_d;
    end
  end

  assign rsp_rd = tag_v_q & ~tag_w_q;

  assign cpu.rvalid = rsp_rd & (tag_p_q == P_CPU);
  assign dbg.rvalid = rsp_rd & (tag_p_q == P_DBG);
  assign cpu.err    = tag_v_q & tag_e_q & (tag_p_q == P_CPU);
  assign dbg.err    = tag_v_q & tag_e_q & (tag_p_q == P_DBG);

  assign cpu.rdata = (cpu.rvalid & ~tag_e_q) ? ram_read_data : '0;
  assign dbg.rdata = (dbg.rvalid & ~tag_e_q) ? ram_read_data : '0;

  assign cnt_cpu = cnt_cpu_q;
  assign cnt_dbg = cnt_dbg_q;
endmodule
